// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Purpose  : Handshake bus for alu_seq. It carries the operand/opcode request
//            channel (valid/ready) and the result/flags response channel
//            (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             cmp_out;

  // Producer/consumer side: presents operands and accepts results
  modport master (
    output in_valid, func, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry, cmp_out
  );

  // ALU side
  modport slave (
    input  in_valid, func, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry, cmp_out
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : WIDTH-bit sequential ALU with registered outputs and valid/ready
//            handshakes. Simple ops complete in one cycle. MUL, DIVU and REMU
//            iterate one bit per cycle for WIDTH cycles.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int MSB   = WIDTH - 1;
  localparam int W1    = WIDTH + 1;
  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       func_q;
  logic [WIDTH-1:0] b_q;
  logic [W2-1:0]    acc_q;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [CNT_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_q;
  logic             cmp_q;

  // Single-cycle datapath, evaluated straight from the bus at the accept edge
  logic [W1-1:0]    add_sum;
  logic [W1-1:0]    sub_dif;
  logic             neg_b_msb;
  logic             sub_ovf;
  logic             slt_ovf;
  logic             is_multi;
  logic             sc_reserved;
  logic [WIDTH-1:0] sc_result;
  logic             sc_zero;
  logic             sc_ovf;
  logic             sc_carry;
  logic             sc_cmp;

  // Iterative datapath
  logic [W1-1:0]    mul_sum;
  logic [W2-1:0]    mul_next;
  logic [W1-1:0]    div_trial;
  logic             div_ge;
  logic [W1-1:0]    div_diff;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    acc_d;
  logic [WIDTH-1:0] fin_result;
  logic             fin_carry;
  logic             fin_ovf;

  // Single-cycle op results and flags
  always_comb begin
    add_sum = {1'b0, bus.a} + {1'b0, bus.b};
    sub_dif = {1'b0, bus.a} + {1'b0, ~bus.b} + W1'(1);
    // Sign of (~b + 1): a nonzero non-negative b negates to a negative value,
    // and the most negative value negates to itself.
    neg_b_msb = bus.b[MSB] ? (bus.b[MSB-1:0] == '0) : (bus.b[MSB-1:0] != '0);
    // SUB flag follows the a/(~b+1) sign rule of the original board ALU
    sub_ovf = (bus.a[MSB] == neg_b_msb) && (sub_dif[MSB] != bus.a[MSB]);
    // SLT needs the true overflow of a-b so the compare is exact even when
    // b is the most negative value
    slt_ovf = (bus.a[MSB] != bus.b[MSB]) && (sub_dif[MSB] != bus.a[MSB]);
    is_multi = (bus.func == OP_MUL) || (bus.func == OP_DIVU) || (bus.func == OP_REMU);

    sc_result   = '0;
    sc_ovf      = 1'b0;
    sc_carry    = 1'b0;
    sc_cmp      = 1'b0;
    sc_reserved = 1'b0;
    case (bus.func)
      OP_ADD: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_carry  = add_sum[WIDTH];
        sc_ovf    = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        sc_result = sub_dif[WIDTH-1:0];
        sc_carry  = sub_dif[WIDTH];
        sc_ovf    = sub_ovf;
      end
      OP_NOT:  sc_result = ~bus.a;
      OP_AND:  sc_result = bus.a & bus.b;
      OP_OR:   sc_result = bus.a | bus.b;
      OP_XOR:  sc_result = bus.a ^ bus.b;
      OP_SLT:  sc_cmp = sub_dif[MSB] ^ slt_ovf;
      OP_EQ:   sc_cmp = (bus.a == bus.b);
      OP_MUL, OP_DIVU, OP_REMU: ;
      default: sc_reserved = 1'b1;
    endcase
    // Reserved opcodes report every flag low, including zero
    sc_zero = !sc_reserved && (sc_result == '0);
  end

  // One shift-add (MUL) or restoring shift-subtract (DIVU/REMU) step
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : W1'(0));
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    div_diff  = div_trial - {1'b0, b_q};
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

    acc_d = (func_q == OP_MUL) ? mul_next : div_next;

    // With b==0 every trial subtract succeeds, so the quotient is all ones
    // and the remainder collects a; only the overflow flag needs adding.
    fin_result = (func_q == OP_REMU) ? acc_d[W2-1:WIDTH] : acc_d[WIDTH-1:0];
    fin_carry  = (func_q == OP_MUL) && (acc_d[W2-1:WIDTH] != '0);
    fin_ovf    = (func_q != OP_MUL) && (b_q == '0);
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      func_q      <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
      cmp_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            func_q <= bus.func;
            b_q    <= bus.b;
            acc_q  <= {{WIDTH{1'b0}}, bus.a};
            if (is_multi) begin
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= S_CALC;
            end else begin
              result_q    <= sc_result;
              zero_q      <= sc_zero;
              overflow_q  <= sc_ovf;
              carry_q     <= sc_carry;
              cmp_q       <= sc_cmp;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= fin_result;
            zero_q      <= (fin_result == '0);
            overflow_q  <= fin_ovf;
            carry_q     <= fin_carry;
            cmp_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry     = carry_q;
  assign bus.cmp_out   = cmp_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=8): directed vector table,
//            backpressure and mid-operation reset sequences, and randomized
//            operations against a plain-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       ov;
    logic       c;
    logic       cmp;
    int         lat;
  } exp_t;

  typedef struct {
    logic [3:0] f;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] res, input logic z, input logic ov,
                                  input logic c, input logic cmp, input int lat);
    exp_t e;
    e.res = res; e.z = z; e.ov = ov; e.c = c; e.cmp = cmp; e.lat = lat;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [3:0] f, input logic [7:0] a,
                                  input logic [7:0] b, input exp_t e);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.e = e;
    return v;
  endfunction

  // Reference model: ordinary integer arithmetic on the operand values
  function automatic exp_t model(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ux, uy, sx, sy, r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = 0;
    e  = mk_exp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    case (f)
      4'd0: begin
        r = ux + uy;
        e.res = r[7:0];
        e.c   = (r > 255);
        e.ov  = (sx + sy > 127) || (sx + sy < -128);
      end
      4'd1: begin
        r = ux - uy;
        e.res = r[7:0];
        e.c   = (ux >= uy);
        // b = -128 negates to itself, so the a/(~b+1) sign rule reduces to a's sign
        e.ov  = (uy == 128) ? x[7] : ((sx - sy > 127) || (sx - sy < -128));
      end
      4'd2: e.res = ~x;
      4'd3: e.res = x & y;
      4'd4: e.res = x | y;
      4'd5: e.res = x ^ y;
      4'd6: e.cmp = (sx < sy);
      4'd7: e.cmp = (ux == uy);
      4'd8: begin
        r = ux * uy;
        e.res = r[7:0];
        e.c   = (r > 255);
        e.lat = W + 1;
      end
      4'd9: begin
        e.lat = W + 1;
        if (uy == 0) begin e.res = 8'hFF; e.ov = 1'b1; end
        else begin r = ux / uy; e.res = r[7:0]; end
      end
      4'd10: begin
        e.lat = W + 1;
        if (uy == 0) begin e.res = x; e.ov = 1'b1; end
        else begin r = ux % uy; e.res = r[7:0]; end
      end
      default: ;
    endcase
    e.z = (f <= 4'd10) && (e.res == 8'h00);
    return e;
  endfunction

  // Issue one op, check latency/results, optionally stall the consumer
  task automatic do_op(input string tag, input logic [3:0] f, input logic [7:0] x,
                       input logic [7:0] y, input int stall, input exp_t e);
    int         lat;
    int         guard;
    logic       ok;
    logic [7:0] held;
    bus.out_ready = (stall == 0);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.func     = f;
    bus.a        = x;
    bus.b        = y;
    @(negedge clk);
    // Scramble the bus after the accept edge: the ALU must use latched values
    bus.in_valid = 1'b0;
    bus.func     = 4'($urandom);
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    lat = 1;
    ok  = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"},  32'(lat), 32'(e.lat));
    chk({tag, ".busy"},     32'(ok & ~bus.in_ready), 32'd1);
    chk({tag, ".result"},   32'(bus.result), 32'(e.res));
    chk({tag, ".zero"},     32'(bus.zero), 32'(e.z));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(e.ov));
    chk({tag, ".carry"},    32'(bus.carry), 32'(e.c));
    chk({tag, ".cmp_out"},  32'(bus.cmp_out), 32'(e.cmp));
    held = bus.result;
    ok   = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.result !== held || bus.in_ready) ok = 1'b0;
    end
    if (stall > 0) chk({tag, ".hold"}, 32'(ok), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".consumed"}, 32'({bus.out_valid, bus.in_ready}), 32'd1);
  endtask

  vec_t tbl[16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    bus.in_valid  = 1'b0;
    bus.func      = 4'd0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.in_ready",  32'(bus.in_ready), 32'd1);
    chk("reset.outputs",   32'({bus.result, bus.zero, bus.overflow, bus.carry, bus.cmp_out}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: {func, a, b} -> {result, zero, overflow, carry, cmp_out, latency}
    tbl[0]  = mk_vec(4'd0,  8'h7F, 8'h01, mk_exp(8'h80, 0, 1, 0, 0, 1));
    tbl[1]  = mk_vec(4'd1,  8'h05, 8'h05, mk_exp(8'h00, 1, 0, 1, 0, 1));
    tbl[2]  = mk_vec(4'd1,  8'h03, 8'h05, mk_exp(8'hFE, 0, 0, 0, 0, 1));
    tbl[3]  = mk_vec(4'd6,  8'hFE, 8'h01, mk_exp(8'h00, 1, 0, 0, 1, 1));
    tbl[4]  = mk_vec(4'd7,  8'h3C, 8'h3C, mk_exp(8'h00, 1, 0, 0, 1, 1));
    tbl[5]  = mk_vec(4'd13, 8'h12, 8'h34, mk_exp(8'h00, 0, 0, 0, 0, 1));
    tbl[6]  = mk_vec(4'd8,  8'h10, 8'h11, mk_exp(8'h10, 0, 0, 1, 0, 9));
    tbl[7]  = mk_vec(4'd9,  8'h64, 8'h07, mk_exp(8'h0E, 0, 0, 0, 0, 9));
    tbl[8]  = mk_vec(4'd10, 8'h64, 8'h07, mk_exp(8'h02, 0, 0, 0, 0, 9));
    tbl[9]  = mk_vec(4'd9,  8'h64, 8'h00, mk_exp(8'hFF, 0, 1, 0, 0, 9));
    tbl[10] = mk_vec(4'd10, 8'h64, 8'h00, mk_exp(8'h64, 0, 1, 0, 0, 9));
    tbl[11] = mk_vec(4'd0,  8'hFF, 8'h01, mk_exp(8'h00, 1, 0, 1, 0, 1));
    tbl[12] = mk_vec(4'd2,  8'h0F, 8'hAA, mk_exp(8'hF0, 0, 0, 0, 0, 1));
    tbl[13] = mk_vec(4'd3,  8'hF0, 8'h3C, mk_exp(8'h30, 0, 0, 0, 0, 1));
    tbl[14] = mk_vec(4'd5,  8'hA5, 8'hA5, mk_exp(8'h00, 1, 0, 0, 0, 1));
    tbl[15] = mk_vec(4'd7,  8'h3C, 8'h3D, mk_exp(8'h00, 1, 0, 0, 0, 1));
    for (int i = 0; i < 16; i++)
      do_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, 0, tbl[i].e);

    // MUL with consumer stalled for three cycles: outputs held, in_ready low
    do_op("mul_stall", 4'd8, 8'h10, 8'h11, 3, mk_exp(8'h10, 0, 0, 1, 0, 9));

    // Reset four cycles into a DIVU aborts it
    bus.in_valid = 1'b1;
    bus.func = 4'd9; bus.a = 8'h64; bus.b = 8'h07;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort.outputs",   32'({bus.result, bus.zero, bus.overflow, bus.carry, bus.cmp_out}), 32'd0);
    chk("abort.in_ready",  32'(bus.in_ready), 32'd1);
    // Requests presented while in reset are ignored
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.func = 4'd0; bus.a = 8'h05; bus.b = 8'h05;
    repeat (3) @(negedge clk);
    chk("abort.ignored", 32'({bus.out_valid, bus.result}), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) ok = 1'b0;
    end
    chk("abort.no_stale", 32'(ok), 32'd1);
    do_op("post_reset_add", 4'd0, 8'h01, 8'h02, 0, mk_exp(8'h03, 0, 0, 0, 0, 1));

    // Randomized ops against the reference model
    for (int i = 0; i < 250; i++) begin
      logic [3:0] f;
      logic [7:0] x, y;
      int         stall;
      f     = 4'($urandom_range(0, 15));
      x     = 8'($urandom);
      y     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 15) == 0) y = 8'h80;
      stall = int'($urandom_range(0, 2));
      do_op($sformatf("rnd%0d_f%0d", i, f), f, x, y, stall, model(f, x, y));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
